// File: rtl/vmmu_write_port.sv
// Write-side client of the video memory arbiter: buffers host pixel writes in a
// FIFO or generates a linear fill run, presenting one entry per arbiter grant.
module vmmu_write_port #(
  parameter int AWIDTH = 19,
  parameter int DWIDTH = 8,
  parameter int FDEPTH = 8,
  parameter int CWIDTH = 19
) (
  input  logic                      MemClk,
  input  logic                      Reset,
  input  logic [AWIDTH-1:0]         HostAddr,
  input  logic [DWIDTH-1:0]         HostData,
  input  logic                      HostWrite,
  output logic                      HostFull,
  output logic                      Overflow,
  output logic [$clog2(FDEPTH):0]   Level,
  input  logic                      FillStart,
  input  logic [AWIDTH-1:0]         FillAddr,
  input  logic [CWIDTH-1:0]         FillCount,
  input  logic [DWIDTH-1:0]         FillData,
  output logic                      FillBusy,
  output logic [AWIDTH-1:0]         ReqAddr,
  output logic [DWIDTH-1:0]         ReqWriteData,
  output logic                      WriteDataTrig,
  input  logic                      WriteDataRdy
);

  localparam int PW = $clog2(FDEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD1, HOLD2} state_t;
  state_t state;

  logic [AWIDTH+DWIDTH-1:0] mem [FDEPTH];
  logic [PW-1:0]            wp, rp;
  logic [AWIDTH-1:0]        fill_addr;
  logic [CWIDTH-1:0]        fill_cnt;
  logic [DWIDTH-1:0]        fill_val;
  logic                     cur_fill;

  logic        empty, pop, push, fill_go;
  logic [PW:0] level_next;

  assign empty   = (Level == '0);
  assign pop     = (state == IDLE) && !FillBusy && !empty;
  // a pop on the same edge frees a slot, so a push into a full FIFO still lands
  assign push    = HostWrite && (!HostFull || pop);
  assign fill_go = FillStart && (state == IDLE) && empty && !FillBusy && (FillCount != '0);

  always_comb begin
    level_next = Level;
    if (push && !pop)
      level_next = Level + 1'b1;
    else if (pop && !push)
      level_next = Level - 1'b1;
  end

  always_ff @(posedge MemClk) begin
    if (push)
      mem[wp] <= {HostAddr, HostData};
  end

  always_ff @(posedge MemClk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      wp            <= '0;
      rp            <= '0;
      Level         <= '0;
      HostFull      <= 1'b0;
      Overflow      <= 1'b0;
      FillBusy      <= 1'b0;
      fill_addr     <= '0;
      fill_cnt      <= '0;
      fill_val      <= '0;
      cur_fill      <= 1'b0;
      ReqAddr       <= '0;
      ReqWriteData  <= '0;
      WriteDataTrig <= 1'b0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      Level    <= level_next;
      HostFull <= (level_next == (PW+1)'(FDEPTH));
      if (HostWrite && !push)
        Overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (FillBusy) begin
            ReqAddr       <= fill_addr;
            ReqWriteData  <= fill_val;
            cur_fill      <= 1'b1;
            WriteDataTrig <= 1'b1;
            state         <= ISSUE;
          end else if (!empty) begin
            {ReqAddr, ReqWriteData} <= mem[rp];
            cur_fill      <= 1'b0;
            WriteDataTrig <= 1'b1;
            state         <= ISSUE;
          end else if (fill_go) begin
            fill_addr <= FillAddr;
            fill_cnt  <= FillCount;
            fill_val  <= FillData;
            FillBusy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (WriteDataRdy) begin
            WriteDataTrig <= 1'b0;
            state         <= HOLD1;
            if (cur_fill) begin
              fill_addr <= fill_addr + 1'b1;
              fill_cnt  <= fill_cnt - 1'b1;
              if (fill_cnt == CWIDTH'(1))
                FillBusy <= 1'b0;
            end
          end
        end
        HOLD1:   state <= HOLD2;
        HOLD2:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmmu_write_port.sv
// Scoreboard bench for vmmu_write_port: expected writes are queued at stimulus
// time and a negedge monitor retires them on each observed grant.
module tb_vmmu_write_port;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int FD = 8;
  localparam int CW = 19;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] HostAddr;
  logic [DW-1:0] HostData;
  logic HostWrite, HostFull, Overflow;
  logic [$clog2(FD):0] Level;
  logic FillStart;
  logic [AW-1:0] FillAddr;
  logic [CW-1:0] FillCount;
  logic [DW-1:0] FillData;
  logic FillBusy;
  logic [AW-1:0] ReqAddr;
  logic [DW-1:0] ReqWriteData;
  logic WriteDataTrig, WriteDataRdy;

  always #5 clk = ~clk;

  vmmu_write_port #(.AWIDTH(AW), .DWIDTH(DW), .FDEPTH(FD), .CWIDTH(CW)) dut (
    .MemClk(clk), .Reset(rst),
    .HostAddr(HostAddr), .HostData(HostData), .HostWrite(HostWrite),
    .HostFull(HostFull), .Overflow(Overflow), .Level(Level),
    .FillStart(FillStart), .FillAddr(FillAddr), .FillCount(FillCount),
    .FillData(FillData), .FillBusy(FillBusy),
    .ReqAddr(ReqAddr), .ReqWriteData(ReqWriteData),
    .WriteDataTrig(WriteDataTrig), .WriteDataRdy(WriteDataRdy)
  );

  ent_t sb[$];
  int   checks = 0;
  int   passed = 0;
  bit   gmode  = 1'b0;
  logic man_rdy = 1'b0;
  logic rand_rdy = 1'b0;

  assign WriteDataRdy = gmode ? rand_rdy : man_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Random grant source, also fires outside the issue window where it must be ignored
  initial forever begin
    tick();
    rand_rdy = ($urandom_range(3) == 0);
  end

  // Monitor: a grant is seen at negedge N (trig && rdy), sampled at edge R;
  // compare after R, then check trig low and outputs stable after R+1, R+2.
  ent_t cap;
  bit   gpend = 1'b0;
  int   hold = 0;
  always @(negedge clk) begin
    if (rst) begin
      gpend = 1'b0;
      hold  = 0;
    end else if (gpend) begin
      gpend = 1'b0;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        chk("wr_addr", cap.a, sb[0].a);
        chk("wr_data", cap.d, sb[0].d);
        void'(sb.pop_front());
      end
      chk("trig_after_grant", WriteDataTrig, 0);
      chk("hold_r0", {ReqAddr, ReqWriteData}, cap);
      hold = 2;
    end else if (hold > 0) begin
      chk("hold_trig", WriteDataTrig, 0);
      chk("hold_out", {ReqAddr, ReqWriteData}, cap);
      hold--;
    end else if (WriteDataTrig) begin
      if (sb.size() == 0) chk("spurious_trig", 1, 0);
      if (WriteDataRdy) begin
        cap   = {ReqAddr, ReqWriteData};
        gpend = 1'b1;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || WriteDataTrig) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 1, 0);
    repeat (4) tick();
  endtask

  task automatic start_fill(input logic [AW-1:0] a, input logic [CW-1:0] c,
                            input logic [DW-1:0] d, input bit expect_acc);
    FillStart = 1'b1; FillAddr = a; FillCount = c; FillData = d;
    if (expect_acc)
      for (int unsigned i = 0; i < c; i++) sb.push_back({a + AW'(i), d});
    tick();
    FillStart = 1'b0;
  endtask

  task automatic push_host(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_acc);
    HostWrite = 1'b1; HostAddr = a; HostData = d;
    if (expect_acc) sb.push_back({a, d});
    tick();
    HostWrite = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; HostWrite = 1'b0; HostAddr = '0; HostData = '0;
    FillStart = 1'b0; FillAddr = '0; FillCount = '0; FillData = '0;
    repeat (2) @(negedge clk);
    chk("rst_addr", ReqAddr, 0);
    chk("rst_data", ReqWriteData, 0);
    chk("rst_trig", WriteDataTrig, 0);
    chk("rst_full", HostFull, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_level", Level, 0);
    chk("rst_busy", FillBusy, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single push: stored on the first edge, presented after the next
    push_host(19'h00010, 8'hA5, 1'b1);
    @(negedge clk);
    chk("lat_trig0", WriteDataTrig, 0);
    chk("lat_level1", Level, 1);
    tick();
    @(negedge clk);
    chk("lat_trig1", WriteDataTrig, 1);
    chk("lat_level0", Level, 0);
    chk("lat_addr", ReqAddr, 19'h00010);
    chk("lat_data", ReqWriteData, 8'hA5);
    tick(); tick();
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    drain();

    // Overflow: one presented plus FD buffered, the rest dropped
    for (int unsigned i = 0; i < FD + 2; i++) begin
      HostWrite = 1'b1; HostAddr = AW'(19'h100 + i); HostData = DW'(i + 1);
      if (i < FD + 1) sb.push_back({AW'(19'h100 + i), DW'(i + 1)});
      tick();
    end
    HostWrite = 1'b0;
    @(negedge clk);
    chk("ovf_full", HostFull, 1);
    chk("ovf_flag", Overflow, 1);
    chk("ovf_level", Level, FD);
    gmode = 1'b1;
    drain();
    chk("ovf_level_drained", Level, 0);
    chk("ovf_full_drained", HostFull, 0);
    chk("ovf_sticky", Overflow, 1);

    // Push coinciding with pop at Level=4
    gmode = 1'b0;
    for (int unsigned i = 0; i < 5; i++) push_host(AW'(19'h200 + i), DW'(8'h50 + i), 1'b1);
    @(negedge clk);
    chk("pp_level_before", Level, 4);
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    tick(); tick();
    push_host(19'h2AA, 8'h5A, 1'b1);
    @(negedge clk);
    chk("pp_level_after", Level, 4);
    chk("pp_trig", WriteDataTrig, 1);
    gmode = 1'b1;
    drain();

    // Fill run wrapping the address space, host pushes queued behind it
    gmode = 1'b0;
    start_fill(19'h7FFFE, 19'd4, 8'h3C, 1'b1);
    @(negedge clk);
    chk("fill_busy", FillBusy, 1);
    push_host(19'h300, 8'h11, 1'b1);
    push_host(19'h301, 8'h22, 1'b1);
    gmode = 1'b1;
    drain();
    chk("fill_busy_done", FillBusy, 0);

    // Zero-length fill is a no-op
    start_fill(19'h400, 19'd0, 8'hFF, 1'b0);
    seen = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      if (WriteDataTrig || FillBusy) seen = 1'b1;
    end
    chk("fill0_quiet", seen, 0);

    // Fill while the FIFO holds entries is ignored
    gmode = 1'b0;
    push_host(19'h500, 8'h01, 1'b1);
    push_host(19'h501, 8'h02, 1'b1);
    start_fill(19'h600, 19'd3, 8'h77, 1'b0);
    @(negedge clk);
    chk("fill_ign_busy", FillBusy, 0);
    gmode = 1'b1;
    drain();
    chk("fill_ign_busy2", FillBusy, 0);

    // Reset in HOLD1 with a fill active and 3 host entries buffered
    gmode = 1'b0;
    start_fill(19'h700, 19'd5, 8'h99, 1'b1);
    for (int unsigned i = 0; i < 3; i++) push_host(AW'(19'h710 + i), DW'(i), 1'b1);
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_addr", ReqAddr, 0);
    chk("mr_data", ReqWriteData, 0);
    chk("mr_trig", WriteDataTrig, 0);
    chk("mr_busy", FillBusy, 0);
    chk("mr_level", Level, 0);
    chk("mr_ovf", Overflow, 0);
    chk("mr_full", HostFull, 0);
    sb.delete();
    tick(); tick();
    rst = 1'b0;
    gmode = 1'b1;
    seen = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (WriteDataTrig) seen = 1'b1;
    end
    chk("mr_no_trig", seen, 0);
    tick();

    // Randomised host traffic with random grants
    for (int unsigned i = 0; i < 600; i++) begin
      if ($urandom_range(1) == 1 && sb.size() < FD) begin
        HostWrite = 1'b1;
        HostAddr  = AW'($urandom);
        HostData  = DW'($urandom);
        sb.push_back({HostAddr, HostData});
      end else begin
        HostWrite = 1'b0;
      end
      tick();
    end
    HostWrite = 1'b0;
    drain();
    chk("rand_level", Level, 0);
    chk("rand_ovf", Overflow, 0);

    start_fill(AW'($urandom), CW'($urandom_range(6, 1)), DW'($urandom), 1'b1);
    drain();
    chk("rand_fill_done", FillBusy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
